serial_rx_deser: RTL
====================

Name: serial_rx_deser

Overview:
- Receiving end of the right-shift parallel-to-serial link: reassembles LSB-first serial frames into w-bit words.
- Frame format: start bit (0), w data bits LSB first, optional parity bit, stop bit (1).
- Bits are qualified by a bit-enable strobe from the transmitter-side bit timer.
- Sits between the serial line and the datapath register file; presents each word with a one-cycle valid pulse.

Parameters:
- w, 4, data word width (bits per frame, w >= 2).
- rst_val, 0, value of q after reset (w bits).

Ports:
- clk  input  1  clock, all state changes on rising edge.
- rst_b  input  1  asynchronous reset, active low.
- bit_en  input  1  synchronous, active high; sin is sampled only on edges where bit_en=1.
- sin  input  1  serial data line, idle level 1.
- clr  input  1  synchronous abort, active high; returns to IDLE and discards the partial word.
- q  output  w  last correctly received word (registered).
- q_vld  output  1  one-cycle pulse when q is updated.
- frm_err  output  1  one-cycle pulse on bad stop bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_b=0, asynchronous, active low; clock clk):
  - State=IDLE, q=rst_val, q_vld=0, frm_err=0, busy=0.
  - Shift register and bit counter cleared to 0.
  - Reset asserted mid-frame discards the frame immediately, with no pulses.
- Priority on each rising edge: rst_b, then clr, then normal operation.
- clr=1 forces IDLE and clears the counter and shift register. q is held; q_vld=0, frm_err=0.
- bit_en=0: state, counter and shift register hold. q_vld and frm_err are forced to 0 (both are pulses).
- FSM, advancing only when bit_en=1:
  - IDLE: sin=0 -> DATA with cnt=0. sin=1 -> stay in IDLE.
  - DATA: sreg <= {sin, sreg[w-1:1]}, cnt <= cnt+1. When cnt==w-1 -> STOP, or PAR when parity is compiled in. After w data bits, sreg holds the word in natural bit order.
  - STOP:
    - sin=1 (good frame): q <= sreg, q_vld=1 for exactly one cycle.
    - sin=0: frm_err=1 for one cycle and q unchanged.
    - Next state is IDLE in both cases.
- Timing and width rules:
  - Latency: q and q_vld are valid right after the clock edge that samples the stop bit.
  - A start bit may be sampled on the very next bit_en after the stop bit, so back-to-back frames are supported.
  - Counter width is $clog2(w). The counter wraps to 0 on entry to IDLE.
- busy=1 in DATA, PAR and STOP.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - Adds state PAR between DATA and STOP; the frame carries one even-parity bit after the data bits.
  - The received parity bit is latched in PAR.
  - In STOP, q_vld fires only if sin=1 and (^sreg ^ par_bit)==0.
  - Adds output par_err (1 bit, reset 0). It pulses for one cycle in STOP when parity mismatches and the stop bit is good; q is unchanged in that case.
  - A bad stop bit raises frm_err only; par_err stays 0.
- Not defined: no PAR state and no par_err port; frame is start + w data + stop.

Test Plan:
- Reset: rst_b=0 at t=1 -> q=0000, q_vld=0, busy=0 without a clock edge. Repeat with rst_val=4'd5 -> q=0101.
- Good frame (w=4), bit_en=1 every cycle, sin sequence 0,1,1,1,0,1 -> q=0111 and q_vld=1 for one cycle after the stop-bit edge; busy high from the edge after the start bit until that edge.
- Framing error: sin sequence 0,0,0,1,1,0 -> frm_err=1 for one cycle, q keeps 0111, q_vld=0.
- Gapped strobe: same frame as the good-frame case with bit_en=1 every third cycle -> q=0111 only after the 6th qualified sample; state holds between strobes.
- Abort and mid-frame reset:
  - clr=1 after two data bits, then full frame 0,0,1,0,1,1 -> q=1010.
  - rst_b=0 after the third data bit -> q=rst_val, busy=0, no q_vld.
- w=8 back-to-back: frames carrying 8'hA5 then 8'h3C with no idle gap -> two q_vld pulses, q=10100101 then 00111100. With SERIAL_RX_PARITY_EN, a wrong parity bit on the 8'h3C frame -> par_err pulse and q stays 8'hA5.

Source files
------------

// File: rtl/serial_rx_deser.sv
// LSB-first serial frame receiver: start(0), w data bits, [even parity], stop(1).
// Optional parity check is compiled in with `define SERIAL_RX_PARITY_EN.
module serial_rx_deser #(
    parameter int             w       = 4,
    parameter logic [w-1:0]   rst_val = '0
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         bit_en,
    input  logic         sin,
    input  logic         clr,
    output logic [w-1:0] q,
    output logic         q_vld,
    output logic         frm_err,
`ifdef SERIAL_RX_PARITY_EN
    output logic         par_err,
`endif
    output logic         busy
);

    localparam int             CW       = $clog2(w);
    localparam logic [CW-1:0]  CNT_LAST = CW'(w - 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [w-1:0]  sreg;
`ifdef SERIAL_RX_PARITY_EN
    logic          par_bit;
    logic          par_ok;

    // Even parity: data bits plus the parity bit must XOR to zero.
    assign par_ok = ~(^sreg ^ par_bit);
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else if (bit_en) begin
            case (state)
                IDLE: if (!sin) state_nxt = DATA;
                DATA: if (cnt == CNT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = STOP;
`endif
                end
                PAR:  state_nxt = STOP;
                STOP: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt     <= '0;
            sreg    <= '0;
            q       <= rst_val;
            q_vld   <= 1'b0;
            frm_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bit <= 1'b0;
            par_err <= 1'b0;
`endif
        end else if (clr) begin
            cnt     <= '0;
            sreg    <= '0;
            q_vld   <= 1'b0;
            frm_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            q_vld   <= 1'b0;
            frm_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_err <= 1'b0;
`endif
            if (bit_en) begin
                case (state)
                    IDLE: cnt <= '0;
                    DATA: begin
                        // Shifting in at the top leaves the word in natural order after w bits.
                        sreg <= {sin, sreg[w-1:1]};
                        cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                    end
`ifdef SERIAL_RX_PARITY_EN
                    PAR:  par_bit <= sin;
`endif
                    STOP: begin
                        if (!sin) begin
                            frm_err <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                        end else if (!par_ok) begin
                            par_err <= 1'b1;
`endif
                        end else begin
                            q     <= sreg;
                            q_vld <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
